tt_um_madhu_add_seq: RTL and testbench
======================================

TT_UM_MADHU_ADD_SEQ -- requirements
Module: tt_um_madhu_add_seq

Interface
REQ-001 The block SHALL have parameter EXEC_CYCLES, default 1, giving the adder execute latency in cycles (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port ena, input, 1, a global enable; while low, all state SHALL hold.
REQ-005 The block SHALL have port ui_in, input, 8, the operand.
REQ-006 The block SHALL have port uio_in, input, 8, with [0]=cmd_valid, [2:1]=opcode, [3]=sat_en and [7:4] unused.
REQ-007 The block SHALL have port uo_out, output, 8, the registered accumulator value.
REQ-008 The block SHALL have port uio_out, output, 8, with [4]=busy, [5]=carry, [6]=done, [7]=zero and [3:0]=0.
REQ-009 The block SHALL have port uio_oe, output, 8, tied constant 8'hF0.

Function
REQ-010 The opcodes SHALL be: 00 LOAD (acc=operand), 01 ADD (acc+=operand), 10 SUB (acc-=operand), 11 CLEAR (acc=0).
REQ-011 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-012 In IDLE with ena=1 and cmd_valid=1, the block SHALL latch operand, opcode and sat_en, load cnt=EXEC_CYCLES-1 and enter EXEC on that edge.
REQ-013 In EXEC, busy SHALL be 1 and cnt SHALL decrement each cycle; at cnt=0 the block SHALL write acc and flags and enter DONE.
REQ-014 The first command SHALL therefore produce a uo_out update EXEC_CYCLES+1 edges after cmd_valid is sampled.
REQ-015 In DONE, done SHALL be 1 and busy 0; the block SHALL return to IDLE on the first edge where cmd_valid=0 (four-phase handshake).
REQ-016 A cmd_valid held high through DONE SHALL NOT retrigger a command.
REQ-017 Changes on ui_in or uio_in[3:1] after the accept edge SHALL NOT affect the executing command.
REQ-018 ADD SHALL form a 9-bit sum with carry=sum[8]; if sat_en=1 and carry=1, acc SHALL be 8'hFF, otherwise acc=sum[7:0].
REQ-019 SUB SHALL set carry=1 (borrow) iff operand>acc; if sat_en=1 and a borrow occurs, acc SHALL be 8'h00, otherwise acc=(acc-operand) mod 256.
REQ-020 LOAD and CLEAR SHALL set carry=0.
REQ-021 zero SHALL equal (new acc==0) and be updated on every command.
REQ-022 Flags SHALL hold their values until the next command completes.
REQ-023 busy SHALL be 1 only in EXEC, and done SHALL be 1 only in DONE.
REQ-024 ena=0 SHALL freeze the state, cnt, acc, flags and all outputs, including mid-EXEC; execution SHALL resume from the same cnt when ena returns to 1.
REQ-025 uio_in[7:4] SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, acc=0, cnt=0, carry=0, zero=0, busy=0, done=0, uo_out=8'h00, uio_out=8'h00.
REQ-027 Assertion of rst_n mid-EXEC or in DONE SHALL abort the command with no acc update.
REQ-028 After reset release, the first accepted command SHALL behave normally.

Structure
REQ-029 Opcode encodings, FSM state encodings and uio bit indices SHALL live in shared package madhu_add_pkg.
REQ-030 The arithmetic (9-bit add/sub, saturation, flag generation) SHALL be one combinational sub-module, madhu_add_alu; the FSM, counter and registers SHALL remain in the top.

Verification
REQ-031 Bench SHALL cover: LOAD 8'h10, then ADD 8'h05 with EXEC_CYCLES=1 -> uo_out=8'h15, carry=0, zero=0; done asserted 2 edges after accept.
REQ-032 Bench SHALL cover: acc=8'hF0, ADD 8'h20, sat_en=0 -> uo_out=8'h10, carry=1; repeat from 8'hF0 with sat_en=1 -> uo_out=8'hFF, carry=1.
REQ-033 Bench SHALL cover: acc=8'h03, SUB 8'h05, sat_en=0 -> 8'hFE, carry=1; with sat_en=1 -> 8'h00, carry=1, zero=1.
REQ-034 Bench SHALL cover: cmd_valid held high 10 cycles after DONE -> exactly one operation; dropping then re-raising cmd_valid -> second operation accepted.
REQ-035 Bench SHALL cover: EXEC_CYCLES=4, ena low 3 cycles mid-EXEC -> done appears at 5+3 edges after accept; ui_in changed mid-EXEC -> no effect on the result.
REQ-036 Bench SHALL cover: rst_n pulsed low mid-EXEC -> uo_out=0 and all uio_out=0 immediately, state IDLE; next LOAD 8'hAA -> uo_out=8'hAA.

Source files
------------

// File: rtl/madhu_add_pkg.sv
// madhu_add_pkg: shared opcode/state encodings and uio bit positions for the sequential adder.
package madhu_add_pkg;
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;
    localparam int UIO_VALID = 0;
    localparam int UIO_OP    = 1;
    localparam int UIO_SAT   = 3;
    localparam int UIO_BUSY  = 4;
    localparam int UIO_CARRY = 5;
    localparam int UIO_DONE  = 6;
    localparam int UIO_ZERO  = 7;
    localparam logic [7:0] UIO_OE = 8'hF0;
endpackage

// File: rtl/madhu_add_alu.sv
// madhu_add_alu: combinational load/add/sub/clear with optional saturation and carry/zero flags.
module madhu_add_alu
    import madhu_add_pkg::*;
(
    input  logic [7:0] acc_i,
    input  logic [7:0] operand_i,
    input  op_e        op_i,
    input  logic       sat_i,
    output logic [7:0] acc_o,
    output logic       carry_o,
    output logic       zero_o
);
    logic [8:0] sum;
    logic [8:0] diff;
    assign sum  = {1'b0, acc_i} + {1'b0, operand_i};
    // diff[8] is the borrow: set exactly when operand exceeds acc
    assign diff = {1'b0, acc_i} - {1'b0, operand_i};
    assign carry_o = (op_i == OP_ADD) ? sum[8] : (op_i == OP_SUB) ? diff[8] : 1'b0;
    assign acc_o = (op_i == OP_LOAD)  ? operand_i :
                   (op_i == OP_CLEAR) ? 8'h00 :
                   (sat_i && carry_o) ? ((op_i == OP_ADD) ? 8'hFF : 8'h00) :
                   (op_i == OP_ADD)   ? sum[7:0] : diff[7:0];
    assign zero_o = (acc_o == 8'h00);
endmodule

// File: rtl/tt_um_madhu_add_seq.sv
// tt_um_madhu_add_seq: handshaked multi-cycle accumulator; outputs are registered one cycle
// behind internal state, so results/done appear EXEC_CYCLES+1 edges after accept.
module tt_um_madhu_add_seq
    import madhu_add_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_e     state_q;
    logic [3:0] cnt_q;
    logic [7:0] acc_q, opd_q, uo_q, uio_q;
    op_e        op_q;
    logic       sat_q, carry_q, zero_q;
    logic [7:0] acc_d;
    logic       carry_d, zero_d;
    logic       unused_ok;
    assign unused_ok = &{1'b0, uio_in[7:4]};
    madhu_add_alu u_alu (
        .acc_i     (acc_q),
        .operand_i (opd_q),
        .op_i      (op_q),
        .sat_i     (sat_q),
        .acc_o     (acc_d),
        .carry_o   (carry_d),
        .zero_o    (zero_d)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            acc_q   <= 8'h00;
            opd_q   <= 8'h00;
            op_q    <= OP_LOAD;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            uo_q    <= 8'h00;
            uio_q   <= 8'h00;
        end else if (ena) begin
            uo_q  <= acc_q;
            uio_q <= {zero_q, state_q == DONE, carry_q, state_q == EXEC, 4'b0000};
            case (state_q)
                IDLE: if (uio_in[UIO_VALID]) begin
                    opd_q   <= ui_in;
                    op_q    <= op_e'(uio_in[UIO_OP +: 2]);
                    sat_q   <= uio_in[UIO_SAT];
                    cnt_q   <= 4'(EXEC_CYCLES - 1);
                    state_q <= EXEC;
                end
                EXEC: if (cnt_q == 4'd0) begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    zero_q  <= zero_d;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: if (!uio_in[UIO_VALID]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = UIO_OE;
endmodule

// File: tb/tb_tt_um_madhu_add_seq.sv
// tb_tt_um_madhu_add_seq: scoreboard bench driving two instances (EXEC_CYCLES 1 and 4).
module tb_tt_um_madhu_add_seq;
    import madhu_add_pkg::*;
    typedef struct {
        logic [7:0] acc;
        bit         c;
        bit         z;
    } exp_t;
    localparam int EC [2] = '{1, 4};
    logic       clk = 1'b0;
    logic       rst_n [2];
    logic       ena   [2];
    logic [7:0] ui    [2];
    logic [7:0] uio   [2];
    logic [7:0] uo    [2];
    logic [7:0] uio_o [2];
    logic [7:0] oe    [2];
    int         n_chk = 0, n_fail = 0;
    int         macc [2];
    exp_t       q0 [$];
    exp_t       q1 [$];
    logic       pd0 = 1'b0, pd1 = 1'b0;

    always #5 clk = ~clk;

    tt_um_madhu_add_seq #(.EXEC_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .ena(ena[0]), .ui_in(ui[0]), .uio_in(uio[0]),
        .uo_out(uo[0]), .uio_out(uio_o[0]), .uio_oe(oe[0]));
    tt_um_madhu_add_seq #(.EXEC_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .ena(ena[1]), .ui_in(ui[1]), .uio_in(uio[1]),
        .uo_out(uo[1]), .uio_out(uio_o[1]), .uio_oe(oe[1]));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int i, input logic [1:0] op, input logic [7:0] d, input bit sat);
        int a, r;
        bit c;
        a = macc[i];
        r = 0;
        c = 0;
        if (op == 2'd0) r = d;
        else if (op == 2'd1) begin
            r = a + d;
            c = r > 255;
            r = (sat && c) ? 255 : r % 256;
        end else if (op == 2'd2) begin
            c = d > a;
            r = (sat && c) ? 0 : (a - d + 256) % 256;
        end
        macc[i] = r;
        return '{8'(r), c, r == 0};
    endfunction

    always @(negedge clk) begin
        if (uio_o[0][6] && !pd0) begin
            if (q0.size() == 0) chk("unexpected_done0", 8'h1, 8'h0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("acc0", uo[0], e.acc);
                chk("carry0", 8'(uio_o[0][5]), 8'(e.c));
                chk("zero0", 8'(uio_o[0][7]), 8'(e.z));
            end
        end
        pd0 <= uio_o[0][6];
    end

    always @(negedge clk) begin
        if (uio_o[1][6] && !pd1) begin
            if (q1.size() == 0) chk("unexpected_done1", 8'h1, 8'h0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("acc1", uo[1], e.acc);
                chk("carry1", 8'(uio_o[1][5]), 8'(e.c));
                chk("zero1", 8'(uio_o[1][7]), 8'(e.z));
            end
        end
        pd1 <= uio_o[1][6];
    end

    task automatic cmd(input int i, input logic [1:0] op, input logic [7:0] d, input bit sat,
                       input bit stall, input int hold);
        exp_t e;
        int   n;
        bit   seen;
        logic bmax;
        e = model(i, op, d, sat);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        ui[i]  = d;
        uio[i] = {4'($urandom), sat, op, 1'b1};
        @(posedge clk);
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            ui[i] = 8'($urandom);
            uio[i][3:1] = 3'($urandom);
            if (stall && n == 2) begin
                ena[i] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("busy_frozen", 8'(uio_o[i][4]), 8'h1);
                n += 3;
                ena[i] = 1'b1;
            end
            seen = uio_o[i][6];
        end
        chk("latency", 8'(n), 8'(EC[i] + 1 + (stall ? 3 : 0)));
        if (hold > 0) begin
            bmax = 1'b0;
            repeat (hold) begin
                @(posedge clk);
                #1;
                bmax |= uio_o[i][4];
            end
            chk("hold_busy", 8'(bmax), 8'h0);
            chk("hold_done", 8'(uio_o[i][6]), 8'h1);
        end
        uio[i][0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("done_drop", 8'(uio_o[i][6]), 8'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            ena[i]   = 1'b1;
            ui[i]    = 8'h00;
            uio[i]   = 8'h00;
            macc[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_uo", uo[i], 8'h00);
            chk("rst_uio", uio_o[i], 8'h00);
            chk("uio_oe", oe[i], 8'hF0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        cmd(0, 2'd0, 8'h10, 0, 0, 0);
        cmd(0, 2'd1, 8'h05, 0, 0, 0);
        cmd(0, 2'd0, 8'hF0, 0, 0, 0);
        cmd(0, 2'd1, 8'h20, 0, 0, 0);
        cmd(0, 2'd0, 8'hF0, 0, 0, 0);
        cmd(0, 2'd1, 8'h20, 1, 0, 0);
        cmd(0, 2'd0, 8'h03, 0, 0, 0);
        cmd(0, 2'd2, 8'h05, 0, 0, 0);
        cmd(0, 2'd0, 8'h03, 0, 0, 0);
        cmd(0, 2'd2, 8'h05, 1, 0, 0);
        cmd(0, 2'd1, 8'h01, 0, 0, 10);
        cmd(0, 2'd1, 8'h01, 0, 0, 0);
        cmd(0, 2'd3, 8'h77, 0, 0, 0);
        cmd(1, 2'd0, 8'h33, 0, 0, 0);
        cmd(1, 2'd1, 8'h11, 0, 1, 0);
        @(negedge clk);
        ui[1]  = 8'h07;
        uio[1] = 8'b0000_0011;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 8'(uio_o[1][4]), 8'h1);
        chk("pre_rst_uo", uo[1], 8'h44);
        rst_n[1] = 1'b0;
        #1;
        chk("rst_mid_uo", uo[1], 8'h00);
        chk("rst_mid_uio", uio_o[1], 8'h00);
        chk("rst_mid_state", 8'(dut1.state_q), 8'(IDLE));
        uio[1] = 8'h00;
        macc[1] = 0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        cmd(1, 2'd0, 8'hAA, 0, 0, 0);
        for (int k = 0; k < 25; k++) begin
            cmd(0, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 0, $urandom_range(0, 2));
            cmd(1, 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
        end
        repeat (3) @(posedge clk);
        chk("q0_empty", 8'(q0.size()), 8'h0);
        chk("q1_empty", 8'(q1.size()), 8'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
